id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I core, with integrated load-use hazard detection and control-hazard flush.
- Captures decoded operands and control from ID and presents them to EX, where the forwarding unit and the operand muxes consume them.
- Generates the stall/flush controls for the PC and the IF/ID register.
- Keeps 32-bit performance counters for bubbles and flushes.

---
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, control-hazard
// flush and saturating bubble/flush performance counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_reg_write,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_auipc,
  input  logic             id_alu_src_b,
  input  logic [1:0]       id_mem_to_reg,
  input  logic [3:0]       id_alu_op,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_rs1_used,
  output logic             ex_rs2_used,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_auipc,
  output logic             ex_alu_src_b,
  output logic [1:0]       ex_mem_to_reg,
  output logic [3:0]       ex_alu_op,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            auipc;
    logic            alu_src_b;
    logic [1:0]      mem_to_reg;
    logic [3:0]      alu_op;
  } stage_t;

  localparam logic [1:0] M2R_LOAD = 2'b11;

  stage_t            st_q, st_d, id_pkt;
  logic [CNT_W-1:0]  bub_q, bub_d, flu_q, flu_d;
  logic              luse;

  // Pack the ID-side fields into one word for capture
  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = id_valid;
    id_pkt.pc         = id_pc;
    id_pkt.imm        = id_imm;
    id_pkt.rs1_data   = id_rs1_data;
    id_pkt.rs2_data   = id_rs2_data;
    id_pkt.rs1        = id_rs1;
    id_pkt.rs2        = id_rs2;
    id_pkt.rd         = id_rd;
    id_pkt.rs1_used   = id_rs1_used;
    id_pkt.rs2_used   = id_rs2_used;
    id_pkt.reg_write  = id_reg_write;
    id_pkt.mem_write  = id_mem_write;
    id_pkt.branch     = id_branch;
    id_pkt.jump       = id_jump;
    id_pkt.auipc      = id_auipc;
    id_pkt.alu_src_b  = id_alu_src_b;
    id_pkt.mem_to_reg = id_mem_to_reg;
    id_pkt.alu_op     = id_alu_op;
  end

  // A load in EX whose destination the ID instruction reads; x0 never hazards
  assign luse = st_q.valid && st_q.reg_write && (st_q.mem_to_reg == M2R_LOAD) &&
                (st_q.rd != 5'd0) && id_valid &&
                ((id_rs1_used && (id_rs1 == st_q.rd)) ||
                 (id_rs2_used && (id_rs2 == st_q.rd)));

  // Hazard priority: memory freeze, then redirect flush, then load-use bubble
  always_comb begin
    st_d        = st_q;
    bub_d       = bub_q;
    flu_d       = flu_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_redirect) begin
      st_d        = '0;
      if_id_flush = 1'b1;
      flu_d       = (flu_q == '1) ? flu_q : flu_q + CNT_W'(1);
    end else if (luse) begin
      st_d        = '0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bub_d       = (bub_q == '1) ? bub_q : bub_q + CNT_W'(1);
    end else begin
      // An invalid ID slot enters EX as a full zero bubble
      st_d = id_valid ? id_pkt : '0;
    end
  end

  // Stage register and counters; reset yields a NOP bubble
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q  <= '0;
      bub_q <= '0;
      flu_q <= '0;
    end else begin
      st_q  <= st_d;
      bub_q <= bub_d;
      flu_q <= flu_d;
    end
  end

  assign ex_valid      = st_q.valid;
  assign ex_pc         = st_q.pc;
  assign ex_imm        = st_q.imm;
  assign ex_rs1_data   = st_q.rs1_data;
  assign ex_rs2_data   = st_q.rs2_data;
  assign ex_rs1        = st_q.rs1;
  assign ex_rs2        = st_q.rs2;
  assign ex_rd         = st_q.rd;
  assign ex_rs1_used   = st_q.rs1_used;
  assign ex_rs2_used   = st_q.rs2_used;
  assign ex_reg_write  = st_q.reg_write;
  assign ex_mem_write  = st_q.mem_write;
  assign ex_branch     = st_q.branch;
  assign ex_jump       = st_q.jump;
  assign ex_auipc      = st_q.auipc;
  assign ex_alu_src_b  = st_q.alu_src_b;
  assign ex_mem_to_reg = st_q.mem_to_reg;
  assign ex_alu_op     = st_q.alu_op;
  assign bubble_cnt    = bub_q;
  assign flush_cnt     = flu_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX state pushed to a scoreboard
// as each step is driven, popped and compared after the capturing edge.
// A second instance with 2-bit counters exercises counter saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rstn;
  logic id_valid;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_rs1_used, id_rs2_used, id_reg_write, id_mem_write, id_branch;
  logic id_jump, id_auipc, id_alu_src_b;
  logic [1:0] id_mem_to_reg;
  logic [3:0] id_alu_op;
  logic ex_redirect, mem_stall;

  logic ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic ex_rs1_used, ex_rs2_used, ex_reg_write, ex_mem_write, ex_branch;
  logic ex_jump, ex_auipc, ex_alu_src_b;
  logic [1:0] ex_mem_to_reg;
  logic [3:0] ex_alu_op;
  logic pc_write, if_id_write, if_id_flush;
  logic [31:0] bubble_cnt, flush_cnt;

  logic s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_imm, s_ex_rs1_data, s_ex_rs2_data;
  logic [4:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic s_ex_rs1_used, s_ex_rs2_used, s_ex_reg_write, s_ex_mem_write, s_ex_branch;
  logic s_ex_jump, s_ex_auipc, s_ex_alu_src_b;
  logic [1:0] s_ex_mem_to_reg;
  logic [3:0] s_ex_alu_op;
  logic s_pc_write, s_if_id_write, s_if_id_flush;
  logic [1:0] s_bubble_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_auipc(id_auipc), .id_alu_src_b(id_alu_src_b),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op), .ex_redirect(ex_redirect),
    .mem_stall(mem_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_auipc(ex_auipc), .ex_alu_src_b(ex_alu_src_b),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_auipc(id_auipc), .id_alu_src_b(id_alu_src_b),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op), .ex_redirect(ex_redirect),
    .mem_stall(mem_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_imm(s_ex_imm),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_rs1(s_ex_rs1),
    .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_rs1_used(s_ex_rs1_used),
    .ex_rs2_used(s_ex_rs2_used), .ex_reg_write(s_ex_reg_write),
    .ex_mem_write(s_ex_mem_write), .ex_branch(s_ex_branch), .ex_jump(s_ex_jump),
    .ex_auipc(s_ex_auipc), .ex_alu_src_b(s_ex_alu_src_b),
    .ex_mem_to_reg(s_ex_mem_to_reg), .ex_alu_op(s_ex_alu_op), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  m2r;
    logic [2:0]  cb;   // {mem_write, branch, jump}
    logic [31:0] bub;
    logic [31:0] flu;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   bub = 0;
  int   flu = 0;

  function automatic logic [1:0] sat2(input int n);
    return (n >= 3) ? 2'd3 : n[1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic [1:0] m2r);
    id_valid = v; id_pc = pc; id_imm = pc ^ 32'h00A5_5A00;
    id_rs1_data = pc + 32'd1; id_rs2_data = pc + 32'd2;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2; id_rd = rd;
    id_reg_write = rw; id_mem_to_reg = m2r; id_mem_write = 1'b0; id_branch = 1'b0;
    id_jump = 1'b0; id_auipc = 1'b0; id_alu_src_b = 1'b0; id_alu_op = 4'h3;
  endtask

  task automatic chk_ctl(input string tag, input logic pw, input logic iw, input logic fl);
    #1;
    chk({tag, ".pc_write"}, 64'(pc_write), 64'(pw));
    chk({tag, ".if_id_write"}, 64'(if_id_write), 64'(iw));
    chk({tag, ".if_id_flush"}, 64'(if_id_flush), 64'(fl));
  endtask

  // mode 0: capture ID, 1: bubble, 2: hold previous
  task automatic push_exp(input int mode);
    exp_t e;
    if (mode == 2) e = last_e;
    else if (mode == 1 || !id_valid) begin
      e.v = 0; e.pc = 0; e.imm = 0; e.rd = 0; e.rw = 0; e.m2r = 0; e.cb = 0;
    end else begin
      e.v = 1; e.pc = id_pc; e.imm = id_pc ^ 32'h00A5_5A00; e.rd = id_rd;
      e.rw = id_reg_write; e.m2r = id_mem_to_reg;
      e.cb = {id_mem_write, id_branch, id_jump};
    end
    e.bub = bub; e.flu = flu;
    last_e = e;
    sb_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(e.v));
      chk({tag, ".ex_pc"}, 64'(ex_pc), 64'(e.pc));
      chk({tag, ".ex_imm"}, 64'(ex_imm), 64'(e.imm));
      chk({tag, ".ex_rd"}, 64'(ex_rd), 64'(e.rd));
      chk({tag, ".ex_reg_write"}, 64'(ex_reg_write), 64'(e.rw));
      chk({tag, ".ex_mem_to_reg"}, 64'(ex_mem_to_reg), 64'(e.m2r));
      chk({tag, ".ex_ctl"}, 64'({ex_mem_write, ex_branch, ex_jump}), 64'(e.cb));
      chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e.bub));
      chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(e.flu));
      chk({tag, ".sat_bubble_cnt"}, 64'(s_bubble_cnt), 64'(sat2(int'(e.bub))));
      chk({tag, ".sat_flush_cnt"}, 64'(s_flush_cnt), 64'(sat2(int'(e.flu))));
    end
  endtask

  initial begin
    // Reset with every ID input high
    rstn = 1'b0; ex_redirect = 1'b0; mem_stall = 1'b0;
    set_id(1'b1, '1, 5'h1f, 1'b1, 5'h1f, 1'b1, 5'h1f, 1'b1, 2'b11);
    id_mem_write = 1'b1; id_branch = 1'b1; id_jump = 1'b1; id_auipc = 1'b1;
    id_alu_src_b = 1'b1; id_alu_op = 4'hf;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ex_reg_write", 64'(ex_reg_write), 64'd0);
    chk("rst.ex_valid", 64'(ex_valid), 64'd0);
    chk("rst.ex_rd", 64'(ex_rd), 64'd0);
    chk("rst.ex_mem_write", 64'(ex_mem_write), 64'd0);
    chk("rst.bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("rst.flush_cnt", 64'(flush_cnt), 64'd0);
    rstn = 1'b1;

    // First instruction after reset
    set_id(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd5, 1, 2'b00);
    chk_ctl("first", 1, 1, 0); push_exp(0); tick("first");

    // Load rd=7, then a consumer of x7 -> one bubble, then capture
    set_id(1, 32'h104, 5'd1, 1, 5'd2, 1, 5'd7, 1, 2'b11);
    chk_ctl("load7", 1, 1, 0); push_exp(0); tick("load7");
    set_id(1, 32'h108, 5'd7, 1, 5'd2, 1, 5'd8, 1, 2'b00);
    bub++; chk_ctl("luse7", 0, 0, 0); push_exp(1); tick("luse7");
    chk_ctl("after_luse7", 1, 1, 0); push_exp(0); tick("after_luse7");

    // False hazard: matching rs1 but rs1 not used
    set_id(1, 32'h10c, 5'd1, 1, 5'd2, 1, 5'd9, 1, 2'b11);
    chk_ctl("load9", 1, 1, 0); push_exp(0); tick("load9");
    set_id(1, 32'h110, 5'd9, 0, 5'd3, 1, 5'd10, 1, 2'b00);
    chk_ctl("nouse9", 1, 1, 0); push_exp(0); tick("nouse9");

    // False hazard: load to x0
    set_id(1, 32'h114, 5'd1, 1, 5'd2, 1, 5'd0, 1, 2'b11);
    chk_ctl("load0", 1, 1, 0); push_exp(0); tick("load0");
    set_id(1, 32'h118, 5'd0, 1, 5'd0, 1, 5'd11, 1, 2'b00);
    chk_ctl("use_x0", 1, 1, 0); push_exp(0); tick("use_x0");

    // Redirect wins over load-use
    set_id(1, 32'h11c, 5'd0, 1, 5'd2, 1, 5'd12, 1, 2'b11);
    chk_ctl("load12", 1, 1, 0); push_exp(0); tick("load12");
    set_id(1, 32'h120, 5'd12, 1, 5'd2, 1, 5'd13, 1, 2'b00);
    ex_redirect = 1'b1; flu++;
    chk_ctl("redir_luse", 1, 1, 1); push_exp(1); tick("redir_luse");
    ex_redirect = 1'b0;

    // mem_stall for 3 cycles with redirect pending, then release
    set_id(1, 32'h124, 5'd1, 1, 5'd2, 1, 5'd14, 1, 2'b00);
    chk_ctl("pre_stall", 1, 1, 0); push_exp(0); tick("pre_stall");
    set_id(1, 32'h128, 5'd1, 1, 5'd2, 1, 5'd15, 1, 2'b00);
    mem_stall = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("stall", 0, 0, 0); push_exp(2); tick("stall");
    end
    mem_stall = 1'b0; flu++;
    chk_ctl("stall_release", 1, 1, 1); push_exp(1); tick("stall_release");
    ex_redirect = 1'b0;

    // Invalid ID slot with control bits set enters as a bubble
    set_id(0, 32'h12c, 5'd1, 1, 5'd2, 1, 5'd16, 1, 2'b11);
    id_mem_write = 1'b1; id_branch = 1'b1; id_jump = 1'b1;
    chk_ctl("invalid", 1, 1, 0); push_exp(0); tick("invalid");

    // Repeated load-use drives the 2-bit counters into saturation
    for (int k = 0; k < 3; k++) begin
      set_id(1, 32'h200 + 32'(k * 16), 5'd1, 1, 5'd2, 1, 5'd20, 1, 2'b11);
      chk_ctl("sat_load", 1, 1, 0); push_exp(0); tick("sat_load");
      set_id(1, 32'h204 + 32'(k * 16), 5'd2, 0, 5'd20, 1, 5'd21, 1, 2'b00);
      bub++; chk_ctl("sat_luse", 0, 0, 0); push_exp(1); tick("sat_luse");
      chk_ctl("sat_cap", 1, 1, 0); push_exp(0); tick("sat_cap");
    end

    // Reset asserted mid-stall: immediate clear, no stall remembered
    set_id(1, 32'h300, 5'd1, 1, 5'd2, 1, 5'd22, 1, 2'b00);
    mem_stall = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("midrst.ex_valid", 64'(ex_valid), 64'd0);
    chk("midrst.ex_rd", 64'(ex_rd), 64'd0);
    chk("midrst.bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("midrst.flush_cnt", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    rstn = 1'b1; mem_stall = 1'b0; bub = 0; flu = 0;
    set_id(1, 32'h304, 5'd1, 1, 5'd2, 1, 5'd5, 1, 2'b00);
    chk_ctl("post_rst", 1, 1, 0); push_exp(0); tick("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
